// File: rtl/led_seq.sv
// LED pattern sequencer: rotate/bounce/blink/fill patterns advanced by a step timer,
// with registered LED drive plus step and wrap pulses for other status logic.
module led_seq #(
  parameter int NUM_LEDS    = 4,
  parameter int CNT_W       = 32,
  parameter int STEP_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                clr,
  input  logic [1:0]          mode,
  input  logic                dir,
  output logic [NUM_LEDS-1:0] led_c,
  output logic                step,
  output logic                wrap
);

  localparam logic [1:0] M_ROTATE = 2'd0;
  localparam logic [1:0] M_BOUNCE = 2'd1;
  localparam logic [1:0] M_BLINK  = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [NUM_LEDS-1:0] led_q, led_d, nxt;
  logic                step_q, step_d, wrap_q, wrap_d;
  logic [1:0]          mode_q, mode_d;
  logic                dir_q, dir_d;
  logic                bdir_q, bdir_d, bdir_nxt, up;

  function automatic logic [NUM_LEDS-1:0] init_pat(input logic [1:0] m, input logic d);
    logic [NUM_LEDS-1:0] p;
    p = '0;
    if (m == M_BLINK) p = '1;
    else if (d)       p[NUM_LEDS-1] = 1'b1;
    else              p[0] = 1'b1;
    return p;
  endfunction

  // bdir_q flips at each end of a bounce so the walk heads back toward INIT
  always_comb begin
    nxt      = led_q;
    bdir_nxt = bdir_q;
    up       = (~dir_q) ^ bdir_q;
    case (mode_q)
      M_ROTATE: nxt = dir_q ? {led_q[0], led_q[NUM_LEDS-1:1]}
                            : {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
      M_BOUNCE: begin
        if (up) begin
          if (led_q[NUM_LEDS-1]) begin
            nxt      = led_q >> 1;
            bdir_nxt = ~bdir_q;
          end else begin
            nxt = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            nxt      = led_q << 1;
            bdir_nxt = ~bdir_q;
          end else begin
            nxt = led_q >> 1;
          end
        end
      end
      M_BLINK:  nxt = ~led_q;
      default: begin
        if (&led_q) nxt = '0;
        else        nxt = dir_q ? {1'b1, led_q[NUM_LEDS-1:1]} : {led_q[NUM_LEDS-2:0], 1'b1};
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    led_d   = led_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    mode_d  = mode_q;
    dir_d   = dir_q;
    bdir_d  = bdir_q;
    if (clr) begin
      state_d = S_IDLE;
      timer_d = '0;
      led_d   = '0;
      bdir_d  = 1'b0;
    end else if (state_q == S_IDLE) begin
      timer_d = '0;
      led_d   = '0;
      if (en) begin
        state_d = S_RUN;
        led_d   = init_pat(mode, dir);
        mode_d  = mode;
        dir_d   = dir;
        bdir_d  = 1'b0;
      end
    end else if (en) begin
      // A mode/dir change restarts the pattern and swallows any step due this edge
      if ({mode, dir} != {mode_q, dir_q}) begin
        timer_d = '0;
        led_d   = init_pat(mode, dir);
        mode_d  = mode;
        dir_d   = dir;
        bdir_d  = 1'b0;
      end else if (timer_q == LAST) begin
        timer_d = '0;
        led_d   = nxt;
        bdir_d  = bdir_nxt;
        step_d  = 1'b1;
        wrap_d  = (nxt == init_pat(mode_q, dir_q));
      end else begin
        timer_d = timer_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      led_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      mode_q  <= '0;
      dir_q   <= 1'b0;
      bdir_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      led_q   <= led_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      bdir_q  <= bdir_d;
    end
  end

  assign led_c = led_q;
  assign step  = step_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_led_seq.sv
// Bench for led_seq: a 4-LED/4-cycle instance for pattern, pause, clear and reset
// behaviour, and an 8-LED/1-cycle instance for single-cycle stepping.
module tb_led_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       en1, clr1, dir1;
  logic [1:0] mode1;
  logic [3:0] led1;
  logic       step1, wrap1;
  logic       en2, clr2, dir2;
  logic [1:0] mode2;
  logic [7:0] led2;
  logic       step2, wrap2;

  led_seq #(.NUM_LEDS(4), .CNT_W(8), .STEP_CYCLES(4)) dut1 (
    .clk(clk), .rstn(rstn), .en(en1), .clr(clr1), .mode(mode1), .dir(dir1),
    .led_c(led1), .step(step1), .wrap(wrap1));

  led_seq #(.NUM_LEDS(8), .CNT_W(4), .STEP_CYCLES(1)) dut2 (
    .clk(clk), .rstn(rstn), .en(en2), .clr(clr2), .mode(mode2), .dir(dir2),
    .led_c(led2), .step(step2), .wrap(wrap2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] led;
    logic       wrap;
    int         at;
  } exp_t;
  exp_t q[$];

  task automatic push(input logic [7:0] l, input logic w, input int at);
    exp_t e;
    e.led = l; e.wrap = w; e.at = at;
    q.push_back(e);
  endtask

  // Waits (bounded) for the next step pulse of the selected instance and reports what it saw
  task automatic next_step(input bit sel, output logic [7:0] l, output logic w,
                           output int at, output bit timeout);
    timeout = 1'b1; l = '0; w = 1'b0; at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sel ? step2 : step1) begin
        l = sel ? led2 : {4'b0000, led1};
        w = sel ? wrap2 : wrap1;
        at = cyc;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    en1 = 0; clr1 = 0; dir1 = 0; mode1 = 2'd0;
    en2 = 0; clr2 = 0; dir2 = 1; mode2 = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({led1, step1, wrap1, led2, step2, wrap2} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got led1=%b s=%b w=%b led2=%b s=%b w=%b, want all zero",
               led1, step1, wrap1, led2, step2, wrap2);
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({led1, step1, wrap1} !== 6'b0) begin
      errors++;
      $display("FAIL idle_hold: got led=%b step=%b wrap=%b, want 0000 0 0", led1, step1, wrap1);
    end
  endtask

  task automatic test_rotate;
    logic [3:0] pat [4];
    logic [7:0] gl; logic gw; int gat; bit gto; exp_t e; int l;
    pat = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    en1 = 1; mode1 = 2'd0; dir1 = 0;
    l = cyc + 1;
    for (int k = 0; k < 4; k++) push({4'b0, pat[k]}, k == 3, l + 4 * (k + 1));
    @(negedge clk);
    checks++;
    if ({led1, step1, wrap1} !== {4'b0001, 2'b00}) begin
      errors++;
      $display("FAIL rotate_load: got led=%b step=%b wrap=%b, want 0001 0 0", led1, step1, wrap1);
    end
    while (q.size() > 0) begin
      next_step(1'b0, gl, gw, gat, gto);
      e = q.pop_front();
      checks++;
      if (gto || {gl, gw} !== {e.led, e.wrap} || gat != e.at) begin
        errors++;
        $display("FAIL rotate_step: got led=%b wrap=%b cyc=%0d timeout=%0b, want led=%b wrap=%b cyc=%0d",
                 gl, gw, gat, gto, e.led, e.wrap, e.at);
      end
    end
  endtask

  task automatic test_bounce;
    logic [3:0] pat [8];
    logic [7:0] gl; logic gw; int gat; bit gto; exp_t e; int l;
    pat = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    mode1 = 2'd1;
    l = cyc + 1;
    for (int k = 0; k < 8; k++) push({4'b0, pat[k]}, k == 5, l + 4 * (k + 1));
    @(negedge clk);
    checks++;
    if ({led1, step1, wrap1} !== {4'b0001, 2'b00}) begin
      errors++;
      $display("FAIL bounce_load: got led=%b step=%b wrap=%b, want 0001 0 0", led1, step1, wrap1);
    end
    while (q.size() > 0) begin
      next_step(1'b0, gl, gw, gat, gto);
      e = q.pop_front();
      checks++;
      if (gto || {gl, gw} !== {e.led, e.wrap} || gat != e.at) begin
        errors++;
        $display("FAIL bounce_step: got led=%b wrap=%b cyc=%0d timeout=%0b, want led=%b wrap=%b cyc=%0d",
                 gl, gw, gat, gto, e.led, e.wrap, e.at);
      end
    end
  endtask

  task automatic test_fill_blink;
    logic [3:0] fp [5];
    logic [3:0] bp [4];
    logic [7:0] gl; logic gw; int gat; bit gto; exp_t e; int l;
    fp = '{4'b1100, 4'b1110, 4'b1111, 4'b0000, 4'b1000};
    bp = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
    mode1 = 2'd3; dir1 = 1;
    l = cyc + 1;
    for (int k = 0; k < 5; k++) push({4'b0, fp[k]}, k == 4, l + 4 * (k + 1));
    @(negedge clk);
    checks++;
    if ({led1, step1, wrap1} !== {4'b1000, 2'b00}) begin
      errors++;
      $display("FAIL fill_load: got led=%b step=%b wrap=%b, want 1000 0 0", led1, step1, wrap1);
    end
    while (q.size() > 0) begin
      next_step(1'b0, gl, gw, gat, gto);
      e = q.pop_front();
      checks++;
      if (gto || {gl, gw} !== {e.led, e.wrap} || gat != e.at) begin
        errors++;
        $display("FAIL fill_step: got led=%b wrap=%b cyc=%0d timeout=%0b, want led=%b wrap=%b cyc=%0d",
                 gl, gw, gat, gto, e.led, e.wrap, e.at);
      end
    end
    mode1 = 2'd2;
    l = cyc + 1;
    for (int k = 0; k < 4; k++) push({4'b0, bp[k]}, bp[k] == 4'b1111, l + 4 * (k + 1));
    @(negedge clk);
    checks++;
    if ({led1, step1, wrap1} !== {4'b1111, 2'b00}) begin
      errors++;
      $display("FAIL blink_load: got led=%b step=%b wrap=%b, want 1111 0 0", led1, step1, wrap1);
    end
    while (q.size() > 0) begin
      next_step(1'b0, gl, gw, gat, gto);
      e = q.pop_front();
      checks++;
      if (gto || {gl, gw} !== {e.led, e.wrap} || gat != e.at) begin
        errors++;
        $display("FAIL blink_step: got led=%b wrap=%b cyc=%0d timeout=%0b, want led=%b wrap=%b cyc=%0d",
                 gl, gw, gat, gto, e.led, e.wrap, e.at);
      end
    end
  endtask

  task automatic test_pause_change;
    logic [7:0] gl; logic gw; int gat; bit gto; exp_t e; bit saw;
    mode1 = 2'd0; dir1 = 0;
    @(negedge clk);
    checks++;
    if ({led1, step1, wrap1} !== {4'b0001, 2'b00}) begin
      errors++;
      $display("FAIL pause_load: got led=%b step=%b wrap=%b, want 0001 0 0", led1, step1, wrap1);
    end
    repeat (2) @(negedge clk);
    en1 = 0;
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (step1 || led1 !== 4'b0001) saw = 1;
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL pause_hold: got led=%b or a step while paused, want 0001 held", led1);
    end
    en1 = 1;
    push(8'b0000_0010, 1'b0, cyc + 2);
    next_step(1'b0, gl, gw, gat, gto);
    e = q.pop_front();
    checks++;
    if (gto || {gl, gw} !== {e.led, e.wrap} || gat != e.at) begin
      errors++;
      $display("FAIL pause_resume: got led=%b wrap=%b cyc=%0d timeout=%0b, want led=%b wrap=%b cyc=%0d",
               gl, gw, gat, gto, e.led, e.wrap, e.at);
    end
    repeat (3) @(negedge clk);
    mode1 = 2'd1;
    push(8'b0000_0010, 1'b0, cyc + 5);
    @(negedge clk);
    checks++;
    if ({led1, step1, wrap1} !== {4'b0001, 2'b00}) begin
      errors++;
      $display("FAIL change_on_step: got led=%b step=%b wrap=%b, want 0001 0 0", led1, step1, wrap1);
    end
    next_step(1'b0, gl, gw, gat, gto);
    e = q.pop_front();
    checks++;
    if (gto || {gl, gw} !== {e.led, e.wrap} || gat != e.at) begin
      errors++;
      $display("FAIL change_next: got led=%b wrap=%b cyc=%0d timeout=%0b, want led=%b wrap=%b cyc=%0d",
               gl, gw, gat, gto, e.led, e.wrap, e.at);
    end
  endtask

  task automatic test_clr_async;
    clr1 = 1;
    @(negedge clk);
    checks++;
    if ({led1, step1, wrap1} !== 6'b0) begin
      errors++;
      $display("FAIL clr_now: got led=%b step=%b wrap=%b, want 0000 0 0", led1, step1, wrap1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (led1 !== 4'b0000 || step1 !== 1'b0) begin
        errors++;
        $display("FAIL clr_hold[%0d]: got led=%b step=%b, want 0000 0", i, led1, step1);
      end
    end
    clr1 = 0;
    @(negedge clk);
    checks++;
    if ({led1, step1, wrap1} !== {4'b0001, 2'b00}) begin
      errors++;
      $display("FAIL clr_reentry: got led=%b step=%b wrap=%b, want 0001 0 0", led1, step1, wrap1);
    end
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({led1, step1, wrap1} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got led=%b step=%b wrap=%b, want 0000 0 0", led1, step1, wrap1);
    end
    en1 = 0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (led1 !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle: got led=%b, want 0000", led1);
    end
  endtask

  task automatic test_fast_rotate;
    logic [7:0] gl; logic gw; int gat; bit gto; exp_t e; int l;
    logic [7:0] p;
    en2 = 1;
    l = cyc + 1;
    p = 8'b1000_0000;
    for (int k = 1; k <= 8; k++) begin
      p = {p[0], p[7:1]};
      push(p, k == 8, l + k);
    end
    @(negedge clk);
    checks++;
    if ({led2, wrap2} !== {8'b1000_0000, 1'b0}) begin
      errors++;
      $display("FAIL fast_load: got led=%b wrap=%b, want 10000000 0", led2, wrap2);
    end
    while (q.size() > 0) begin
      next_step(1'b1, gl, gw, gat, gto);
      e = q.pop_front();
      checks++;
      if (gto || {gl, gw} !== {e.led, e.wrap} || gat != e.at) begin
        errors++;
        $display("FAIL fast_step: got led=%b wrap=%b cyc=%0d timeout=%0b, want led=%b wrap=%b cyc=%0d",
                 gl, gw, gat, gto, e.led, e.wrap, e.at);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_bounce();
    test_fill_blink();
    test_pause_change();
    test_clr_async();
    test_fast_rotate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
